// File: rtl/lorenz_pkg.sv
// lorenz_pkg: shared frame geometry and sequencer state encoding.
package lorenz_pkg;
  localparam int BMP_HDR_BYTES = 54;
  localparam int FRAME_PIXEL_BYTES = 786432;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_HEADER = 3'd1;
  localparam state_t ST_PIXELS = 3'd2;
  localparam state_t ST_FLUSH  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;
endpackage

// File: rtl/lorenz_out_reg.sv
// lorenz_out_reg: one-entry valid/ready output register carrying tlast.
module lorenz_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       last_i,
  input  logic       tready_i,
  output logic [7:0] tdata_o,
  output logic       tvalid_o,
  output logic       tlast_o,
  output logic       free_o
);
  logic [7:0] data_q;
  logic       valid_q;
  logic       last_q;
  assign free_o   = !valid_q | tready_i;
  assign tdata_o  = data_q;
  assign tvalid_o = valid_q;
  assign tlast_o  = last_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
      last_q  <= last_i;
    end else if (tready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
endmodule

// File: rtl/lorenz_frame_sequencer.sv
// lorenz_frame_sequencer: bypasses the BMP header, then joins pixel and key bytes into the encryptor core.
module lorenz_frame_sequencer
  import lorenz_pkg::*;
#(
  parameter int HDR_BYTES       = BMP_HDR_BYTES,
  parameter int PIXEL_BYTES     = FRAME_PIXEL_BYTES,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] s_axis_byte_tdata,
  input  logic       s_axis_byte_tvalid,
  output logic       s_axis_byte_tready,
  input  logic [7:0] s_axis_key_tdata,
  input  logic       s_axis_key_tvalid,
  output logic       s_axis_key_tready,
  output logic [7:0] core_req_pixel,
  output logic [7:0] core_req_key,
  output logic       core_req_valid,
  input  logic       core_req_ready,
  input  logic [7:0] core_rsp_tdata,
  input  logic       core_rsp_tvalid,
  output logic       core_rsp_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       busy,
  output logic       done
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BYTES - 1);
  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXEL_BYTES - 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  state_t state_q, state_d;
  logic [CNT_W-1:0] hdr_cnt_q, hdr_cnt_d, pix_cnt_q, pix_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic out_free, in_hdr, in_pix, draining, hdr_acc, issue, rsp_acc, last_hs;
  assign in_hdr   = state_q == ST_HEADER;
  assign in_pix   = state_q == ST_PIXELS;
  assign draining = in_pix | (state_q == ST_FLUSH);
  // Pixel and key are consumed together or not at all.
  assign core_req_valid     = in_pix & s_axis_byte_tvalid & s_axis_key_tvalid & (out_cnt_q < OUT_MAX);
  assign issue              = core_req_valid & core_req_ready;
  assign core_req_pixel     = s_axis_byte_tdata;
  assign core_req_key       = s_axis_key_tdata;
  assign s_axis_byte_tready = in_hdr ? out_free : issue;
  assign s_axis_key_tready  = issue;
  assign core_rsp_tready    = draining & out_free;
  assign hdr_acc            = in_hdr & s_axis_byte_tvalid & out_free;
  assign rsp_acc            = core_rsp_tready & core_rsp_tvalid;
  assign last_hs            = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign busy               = state_q != ST_IDLE;
  assign done               = state_q == ST_DONE;
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q + CNT_W'(hdr_acc);
    pix_cnt_d = pix_cnt_q + CNT_W'(issue);
    rsp_cnt_d = rsp_cnt_q + CNT_W'(rsp_acc);
    out_cnt_d = out_cnt_q + OW'(issue) - OW'(rsp_acc);
    case (state_q)
      ST_IDLE:
        if (start) begin
          state_d   = ST_HEADER;
          hdr_cnt_d = '0;
          pix_cnt_d = '0;
          rsp_cnt_d = '0;
          out_cnt_d = '0;
        end
      ST_HEADER: if (hdr_acc && hdr_cnt_q == HDR_LAST) state_d = ST_PIXELS;
      ST_PIXELS: if (issue && pix_cnt_q == PIX_LAST) state_d = ST_FLUSH;
      ST_FLUSH:  if (out_cnt_q == '0 && last_hs) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= '0;
      pix_cnt_q <= '0;
      rsp_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  lorenz_out_reg u_out (
    .clk      (clk),
    .rst      (rst),
    .load_i   (hdr_acc | rsp_acc),
    .data_i   (in_hdr ? s_axis_byte_tdata : core_rsp_tdata),
    .last_i   (rsp_acc && rsp_cnt_q == PIX_LAST),
    .tready_i (m_axis_tready),
    .tdata_o  (m_axis_tdata),
    .tvalid_o (m_axis_tvalid),
    .tlast_o  (m_axis_tlast),
    .free_o   (out_free)
  );
endmodule

// File: tb/tb_lorenz_frame_sequencer.sv
// tb_lorenz_frame_sequencer: randomized frames against an XOR core model with a scoreboard on the output stream.
module tb_lorenz_frame_sequencer;
  localparam int HDR = 4, PIX = 8, MAXO = 4, CW = 4, NB = HDR + PIX;
  logic clk = 0, rst = 0, start = 0;
  logic [7:0] s_axis_byte_tdata = 0, s_axis_key_tdata = 0, core_rsp_tdata = 0;
  logic s_axis_byte_tvalid = 0, s_axis_key_tvalid = 0, core_req_ready = 0;
  logic core_rsp_tvalid = 0, m_axis_tready = 0;
  logic s_axis_byte_tready, s_axis_key_tready, core_req_valid, core_rsp_tready;
  logic [7:0] core_req_pixel, core_req_key, m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, busy, done;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;

  lorenz_frame_sequencer #(.HDR_BYTES(HDR), .PIXEL_BYTES(PIX), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_axis_byte_tdata(s_axis_byte_tdata), .s_axis_byte_tvalid(s_axis_byte_tvalid), .s_axis_byte_tready(s_axis_byte_tready),
    .s_axis_key_tdata(s_axis_key_tdata), .s_axis_key_tvalid(s_axis_key_tvalid), .s_axis_key_tready(s_axis_key_tready),
    .core_req_pixel(core_req_pixel), .core_req_key(core_req_key), .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_rsp_tdata(core_rsp_tdata), .core_rsp_tvalid(core_rsp_tvalid), .core_rsp_tready(core_rsp_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done)
  );

  typedef struct {logic [7:0] d; int due;} rsp_t;
  typedef struct {logic [7:0] d; logic l;} exp_t;
  rsp_t pipe[$];
  exp_t exp_q[$];
  exp_t mon_e;
  logic [7:0] frm[NB];
  logic [7:0] keys[PIX];
  logic [7:0] hdr_fix[HDR] = '{8'h42, 8'h4D, 8'h10, 8'h00};
  bit en = 0, rnd = 0, gap_drv = 0;
  int lat = 1, tr_mode = 0, gap_len = 0;
  int b_idx, k_idx, n_issue, gap_left, gap_viol, stall_cnt, max_inflight, hdr_key_hs, cyc;
  int mcyc = 0, last_cyc = -10, done_cnt = 0, tlast_cnt = 0, nfr = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Sources, XOR core model and sink: sample handshakes at negedge, act just after posedge.
  initial begin : drive
    bit b_hs, k_hs, q_hs, r_hs;
    logic [7:0] q_d;
    forever begin
      @(negedge clk);
      b_hs = s_axis_byte_tvalid & s_axis_byte_tready;
      k_hs = s_axis_key_tvalid & s_axis_key_tready;
      q_hs = core_req_valid & core_req_ready;
      q_d  = core_req_pixel ^ core_req_key;
      r_hs = core_rsp_tvalid & core_rsp_tready;
      if (gap_drv && (b_hs || q_hs)) gap_viol++;
      if (k_hs && b_idx < HDR) hdr_key_hs++;
      if (s_axis_byte_tvalid && s_axis_key_tvalid && b_idx >= HDR && !core_req_valid) stall_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst || !en) begin
        b_idx = 0; k_idx = 0; n_issue = 0; pipe.delete(); gap_left = gap_len;
        gap_viol = 0; stall_cnt = 0; max_inflight = 0; hdr_key_hs = 0; gap_drv = 0;
        s_axis_byte_tvalid = 0; s_axis_key_tvalid = 0; core_rsp_tvalid = 0;
      end else begin
        if (b_hs) b_idx++;
        if (k_hs) k_idx++;
        if (q_hs) begin n_issue++; pipe.push_back('{q_d, cyc + lat - 1}); end
        if (r_hs) void'(pipe.pop_front());
        if (pipe.size() > max_inflight) max_inflight = pipe.size();
        s_axis_byte_tvalid = b_idx < NB && ((s_axis_byte_tvalid && !b_hs) || !rnd || $urandom_range(0, 3) != 0);
        s_axis_byte_tdata  = frm[b_idx < NB ? b_idx : 0];
        gap_drv = k_idx == 3 && gap_left > 0;
        if (gap_drv) gap_left--;
        s_axis_key_tvalid = !gap_drv && k_idx < PIX && ((s_axis_key_tvalid && !k_hs) || !rnd || $urandom_range(0, 3) != 0);
        s_axis_key_tdata  = keys[k_idx < PIX ? k_idx : 0];
        core_rsp_tvalid = pipe.size() > 0 && pipe[0].due <= cyc;
        core_rsp_tdata  = pipe.size() > 0 ? pipe[0].d : 8'h00;
      end
      core_req_ready = !rnd || $urandom_range(0, 3) != 0;
      m_axis_tready  = tr_mode == 0 ? 1'b1 : tr_mode == 1 ? !m_axis_tready : 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    mcyc++;
    if (rst && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got %0h with nothing required", m_axis_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_byte{tlast,data}", {23'd0, m_axis_tlast, m_axis_tdata}, {23'd0, mon_e.l, mon_e.d});
      end
      if (m_axis_tlast) begin tlast_cnt++; last_cyc = mcyc; end
    end
    if (rst && done) begin
      done_cnt++;
      check("done_after_tlast", mcyc, last_cyc + 1);
    end
  end

  task automatic load_frame(bit fixed_hdr);
    en = 0;
    @(posedge clk); #2;
    for (int i = 0; i < NB; i++) frm[i] = (fixed_hdr && i < HDR) ? hdr_fix[i] : 8'($urandom);
    for (int j = 0; j < PIX; j++) keys[j] = 8'($urandom);
    for (int i = 0; i < HDR; i++) exp_q.push_back('{frm[i], 1'b0});
    for (int j = 0; j < PIX; j++) exp_q.push_back('{frm[HDR + j] ^ keys[j], j == PIX - 1});
    en = 1;
    start = 1;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic pulse_when(bit on_flush);
    int t = 0;
    while ((on_flush ? n_issue != PIX : b_idx != 2) && t < 500) begin @(posedge clk); #2; t++; end
    check(on_flush ? "reach_flush" : "reach_header2", t < 500, 1);
    start = 1;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic run_frame(int l, int g, int tm, bit r, bit glitch, bit fixed_hdr);
    int t = 0;
    int tl0 = tlast_cnt;
    lat = l; gap_len = g; tr_mode = tm; rnd = r;
    load_frame(fixed_hdr);
    if (glitch) begin pulse_when(0); pulse_when(1); end
    do begin @(negedge clk); t++; end while (!done && t < 2000);
    nfr++;
    check("done_seen", done, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("all_bytes_out", exp_q.size(), 0);
    check("tlast_once", tlast_cnt - tl0, 1);
    check("key_idle_in_header", hdr_key_hs, 0);
    check("inflight_le_max", max_inflight <= MAXO, 1);
    if (g > 0) check("no_consume_in_gap", gap_viol, 0);
    if (l >= 10) check("issue_stalled", stall_cnt > 0, 1);
  endtask

  task automatic check_reset_outs(string name);
    check(name, {s_axis_byte_tready, s_axis_key_tready, core_req_valid, core_rsp_tready,
                 m_axis_tvalid, m_axis_tlast, busy, done, m_axis_tdata}, 0);
  endtask

  task automatic reset_mid_frame;
    int t = 0;
    lat = 1; gap_len = 0; tr_mode = 0; rnd = 0;
    load_frame(0);
    while (n_issue < 3 && t < 500) begin @(posedge clk); #2; t++; end
    check("three_issues", n_issue, 3);
    #1 rst = 0;
    #1 check_reset_outs("async_reset_outputs");
    exp_q.delete();
    en = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outs("reset_outputs");
    @(posedge clk); #3 rst = 1;
    run_frame(1, 0, 0, 0, 0, 1);
    run_frame(1, 5, 0, 0, 0, 1);
    run_frame(10, 0, 0, 0, 0, 0);
    run_frame(2, 0, 1, 0, 0, 0);
    reset_mid_frame();
    run_frame(1, 0, 0, 0, 0, 1);
    run_frame(3, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) run_frame($urandom_range(1, 6), 0, 2, 1, 0, 0);
    check("done_pulse_total", done_cnt, nfr);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
